tiled_matmul_sequencer: RTL
===========================

Name: tiled_matmul_sequencer

Overview:
- Parametrised successor to the TPU control unit. Sequences a full tiled matrix multiply: N output-column tiles × K reduction tiles, with runtime tile counts and row count.
- Drives the weight FIFO, activation reads from the unified buffer, the systolic MAC array, and the skewed, masked read-modify-write of the accumulators.
- Adds start/busy/done handshake, accumulate-into-existing mode and abort.

Parameters:
MUL_SIZE, 32, systolic array dimension (lanes); power of two ≥4
DIM_W, 9, width of row-count field
TILE_W, 4, width of tile-count fields
UB_ADDR_W, 12, unified buffer address width
ACC_ADDR_W, 10, accumulator address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start pulse; sampled only in IDLE
abort_i  in  1  abandon operation
cfg_rows_i  in  DIM_W  activation rows per pass minus 1 (R = cfg_rows_i+1)
cfg_k_tiles_i  in  TILE_W  reduction tiles minus 1 (K = value+1)
cfg_n_tiles_i  in  TILE_W  output-column tiles minus 1 (N = value+1)
cfg_ub_base_i  in  UB_ADDR_W  unified buffer activation base
cfg_acc_base_i  in  ACC_ADDR_W  accumulator base
cfg_accumulate_i  in  1  1: first k-pass adds to existing accumulator contents
weight_fifo_full_i  in  1  weight FIFO holds a full tile
weight_valid_i  in  1  weight FIFO output beat valid
act_rdy_i  in  1  first activation row available at array input
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
load_weights_o  out  1  shift weights into array
load_activations_o  out  1  feed activation row
stall_compute_o  out  1  freeze array
mac_compute_o  out  1  MAC enable
ub_addr_rd_o  out  UB_ADDR_W  activation read address
acc_rd_o  out  1  accumulator read strobe
acc_wr_o  out  1  accumulator write strobe
acc_add_o  out  1  write = read + result (else overwrite)
acc_addr_rd_o  out  ACC_ADDR_W  accumulator read address
acc_addr_wr_o  out  ACC_ADDR_W  accumulator write address
acc_mask_o  out  MUL_SIZE  lane write mask; MSB = lane 0

Behaviour:
- All outputs are registered. Reset and IDLE values: every strobe and mask is 0, stall_compute_o=1, and all addresses are 0.
- In IDLE with start_i high, all cfg_* inputs are latched and busy_o rises next cycle. Derived values: S = R+MUL_SIZE-1 (accumulator row stride), P = 2·MUL_SIZE+R-1 (pass length).
- States: IDLE → WAIT_FIFO → LOAD_W → WAIT_ACT → COMPUTE → (next pass: WAIT_FIFO | final: DONE) → IDLE.
- WAIT_FIFO: hold until weight_fifo_full_i.
- LOAD_W:
  - load_weights_o=1.
  - A beat counter increments on weight_valid_i.
  - Exit after MUL_SIZE beats. Stall on gaps; never count without valid.
- WAIT_ACT: load_activations_o=1, ub_addr_rd_o = ub_base + k·R. Hold until act_rdy_i.
- COMPUTE, pass cycle p = 0..P-1:
  - mac_compute_o=1, stall_compute_o=0.
  - load_activations_o=1 for p<R. ub_addr_rd_o = ub_base + k·R + p + 1, with the +1 term saturated at R-1.
  - Output row j = p-MUL_SIZE, defined for p≥MUL_SIZE. Cycles p<MUL_SIZE are fill: acc_wr_o=0 and acc_mask_o=0.
  - For p≥MUL_SIZE: acc_wr_o=1 and acc_addr_wr_o = acc_base + n·S + j. Mask bit for lane l (bit MUL_SIZE-1-l) is 1 iff 0 ≤ j-l ≤ R-1.
  - acc_add_o = (k>0) | accumulate. It is constant for the whole pass.
  - When acc_add_o=1, acc_rd_o=1 for p = MUL_SIZE-1..P-2 with acc_addr_rd_o = acc_base + n·S + (p-MUL_SIZE+1). The read therefore leads the write to the same address by exactly one cycle. When acc_add_o=0, acc_rd_o=0.
- Pass order: k inner, n outer. At p=P-1 the pass counter advances: k wraps to 0 and increments n.
- After the final pass (n=N-1, k=K-1), go to DONE. DONE pulses done_o for one cycle, drops busy_o, and returns to IDLE.
- Address arithmetic is modulo 2^width and wraps silently. Configurations exceeding the address range are the software's responsibility.
- start_i while busy is ignored. The latched config is immune to cfg_* changes mid-operation.
- abort_i in any non-IDLE state: next cycle IDLE, reset values, no done_o. If abort_i and the final pass end coincide, abort wins.
- rst_ni low at any time forces IDLE and reset values asynchronously. Counters clear.

Test Plan:
- MUL_SIZE=4, R=2, K=N=1, accumulate=0. Required response:
  - P=9 cycles with 5 write cycles.
  - Masks in order: 1000, 1100, 0110, 0011, 0001.
  - Write addresses: base+0..4.
  - acc_rd_o never asserted. One done_o pulse.
- MUL_SIZE=4, R=3, K=2, N=2, acc_base=16. Required response:
  - Passes run in (n,k) order 00, 01, 10, 11.
  - acc_add_o=0 on k=0 passes and 1 on k=1 passes.
  - Pass n=1 writes start at 16+6=22.
  - Every acc_rd_o precedes the write to the same address by one cycle.
- accumulate=1, K=N=1 → acc_add_o=1 and acc_rd_o active from the first pass.
- weight_valid_i toggling 1,0,1,0 during LOAD_W → exactly MUL_SIZE valid beats counted before WAIT_ACT.
- abort_i at COMPUTE p=3 → IDLE next cycle, all strobes 0, busy_o=0, no done_o. A subsequent start_i runs normally.
- start_i during busy and cfg_rows_i changed mid-run → no effect on sequence or addresses. rst_ni pulsed low mid-COMPUTE → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/tiled_matmul_sequencer_if.sv
// Control bundle between the tiled matmul sequencer and its host/datapath.
// slave = sequencer side, master = host/datapath side.
interface tiled_matmul_sequencer_if #(
  parameter int MUL_SIZE   = 32,
  parameter int DIM_W      = 9,
  parameter int TILE_W     = 4,
  parameter int UB_ADDR_W  = 12,
  parameter int ACC_ADDR_W = 10
);
  logic                  start_i;
  logic                  abort_i;
  logic [DIM_W-1:0]      cfg_rows_i;
  logic [TILE_W-1:0]     cfg_k_tiles_i;
  logic [TILE_W-1:0]     cfg_n_tiles_i;
  logic [UB_ADDR_W-1:0]  cfg_ub_base_i;
  logic [ACC_ADDR_W-1:0] cfg_acc_base_i;
  logic                  cfg_accumulate_i;
  logic                  weight_fifo_full_i;
  logic                  weight_valid_i;
  logic                  act_rdy_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  load_weights_o;
  logic                  load_activations_o;
  logic                  stall_compute_o;
  logic                  mac_compute_o;
  logic [UB_ADDR_W-1:0]  ub_addr_rd_o;
  logic                  acc_rd_o;
  logic                  acc_wr_o;
  logic                  acc_add_o;
  logic [ACC_ADDR_W-1:0] acc_addr_rd_o;
  logic [ACC_ADDR_W-1:0] acc_addr_wr_o;
  logic [MUL_SIZE-1:0]   acc_mask_o;

  modport slave (
    input  start_i, abort_i, cfg_rows_i, cfg_k_tiles_i,
    input  cfg_n_tiles_i, cfg_ub_base_i, cfg_acc_base_i,
    input  cfg_accumulate_i, weight_fifo_full_i,
    input  weight_valid_i, act_rdy_i,
    output busy_o, done_o, load_weights_o,
    output load_activations_o, stall_compute_o,
    output mac_compute_o, ub_addr_rd_o, acc_rd_o,
    output acc_wr_o, acc_add_o, acc_addr_rd_o,
    output acc_addr_wr_o, acc_mask_o
  );

  modport master (
    output start_i, abort_i, cfg_rows_i, cfg_k_tiles_i,
    output cfg_n_tiles_i, cfg_ub_base_i, cfg_acc_base_i,
    output cfg_accumulate_i, weight_fifo_full_i,
    output weight_valid_i, act_rdy_i,
    input  busy_o, done_o, load_weights_o,
    input  load_activations_o, stall_compute_o,
    input  mac_compute_o, ub_addr_rd_o, acc_rd_o,
    input  acc_wr_o, acc_add_o, acc_addr_rd_o,
    input  acc_addr_wr_o, acc_mask_o
  );
endinterface

// File: rtl/tiled_matmul_sequencer.sv
// Tiled matmul sequencer: N column tiles x K reduction tiles,
// weight load, activation feed, skewed masked accumulator RMW.
module tiled_matmul_sequencer #(
  parameter int MUL_SIZE   = 32,
  parameter int DIM_W      = 9,
  parameter int TILE_W     = 4,
  parameter int UB_ADDR_W  = 12,
  parameter int ACC_ADDR_W = 10
) (
  input logic clk_i,
  input logic rst_ni,
  tiled_matmul_sequencer_if.slave bus
);
  localparam int BW = $clog2(MUL_SIZE);
  localparam int PW = DIM_W + BW + 2;
  localparam int UW = UB_ADDR_W;
  localparam int AW = ACC_ADDR_W;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MUL_SIZE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_FIFO = 3'd1;
  localparam logic [2:0] S_LOAD_W    = 3'd2;
  localparam logic [2:0] S_WAIT_ACT  = 3'd3;
  localparam logic [2:0] S_COMPUTE   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]        r_state;
  logic [PW-1:0]     r_p;
  logic [BW-1:0]     r_beat;
  logic [TILE_W-1:0] r_k;
  logic [TILE_W-1:0] r_n;

  logic [DIM_W-1:0]  r_rows;
  logic [TILE_W-1:0] r_kt;
  logic [TILE_W-1:0] r_nt;
  logic [UW-1:0]     r_ub;
  logic [AW-1:0]     r_acc;
  logic              r_accum;

  logic              r_busy;
  logic              r_done;
  logic              r_ldw;
  logic              r_lda;
  logic              r_stall;
  logic              r_mac;
  logic [UW-1:0]     r_ub_addr;
  logic              r_rd;
  logic              r_wr;
  logic              r_add;
  logic [AW-1:0]     r_rd_addr;
  logic [AW-1:0]     r_wr_addr;
  logic [MUL_SIZE-1:0] r_mask;

  logic [2:0]        w_state_n;
  logic [PW-1:0]     w_p_n;
  logic [BW-1:0]     w_beat_n;
  logic [TILE_W-1:0] w_k_n;
  logic [TILE_W-1:0] w_n_n;

  logic [PW-1:0]     w_r;
  logic [PW-1:0]     w_s;
  logic [PW-1:0]     w_plast;
  logic [PW-1:0]     w_off;
  logic [UW-1:0]     w_ub_k;
  logic [AW-1:0]     w_acc_n;

  logic              w_busy;
  logic              w_done;
  logic              w_ldw;
  logic              w_lda;
  logic              w_stall;
  logic              w_mac;
  logic [UW-1:0]     w_ub_addr;
  logic              w_rd;
  logic              w_wr;
  logic              w_add;
  logic [AW-1:0]     w_rd_addr;
  logic [AW-1:0]     w_wr_addr;
  logic [MUL_SIZE-1:0] w_mask;

  assign w_r     = PW'(r_rows) + PW'(1);
  assign w_s     = w_r + PW'(MUL_SIZE - 1);
  assign w_plast = w_r + PW'(2 * MUL_SIZE - 2);
  assign w_ub_k  = r_ub + UW'(w_k_n) * UW'(w_r);
  assign w_acc_n = r_acc + AW'(w_n_n) * AW'(w_s);
  assign w_off   = (w_p_n >= PW'(r_rows)) ? PW'(r_rows)
                                          : w_p_n + PW'(1);

  // Next state and pass/beat counters; abort overrides everything.
  always_comb begin
    w_state_n = r_state;
    w_p_n     = r_p;
    w_beat_n  = r_beat;
    w_k_n     = r_k;
    w_n_n     = r_n;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_n = S_WAIT_FIFO;
          w_p_n     = '0;
          w_beat_n  = '0;
          w_k_n     = '0;
          w_n_n     = '0;
        end
      end
      S_WAIT_FIFO: begin
        if (bus.weight_fifo_full_i) begin
          w_state_n = S_LOAD_W;
          w_beat_n  = '0;
        end
      end
      S_LOAD_W: begin
        if (bus.weight_valid_i) begin
          if (r_beat == BEAT_LAST) begin
            w_state_n = S_WAIT_ACT;
            w_beat_n  = '0;
          end else begin
            w_beat_n = r_beat + BW'(1);
          end
        end
      end
      S_WAIT_ACT: begin
        if (bus.act_rdy_i) begin
          w_state_n = S_COMPUTE;
          w_p_n     = '0;
        end
      end
      S_COMPUTE: begin
        if (r_p == w_plast) begin
          w_p_n     = '0;
          w_state_n = S_WAIT_FIFO;
          if (r_k == r_kt) begin
            w_k_n = '0;
            if (r_n == r_nt) begin
              w_state_n = S_DONE;
            end else begin
              w_n_n = r_n + TILE_W'(1);
            end
          end else begin
            w_k_n = r_k + TILE_W'(1);
          end
        end else begin
          w_p_n = r_p + PW'(1);
        end
      end
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (bus.abort_i && (r_state != S_IDLE)) begin
      w_state_n = S_IDLE;
      w_p_n     = '0;
      w_beat_n  = '0;
      w_k_n     = '0;
      w_n_n     = '0;
    end
  end

  // Decode outputs from the next state so they register in step with it.
  always_comb begin
    w_busy    = (w_state_n != S_IDLE) && (w_state_n != S_DONE);
    w_done    = (w_state_n == S_DONE);
    w_ldw     = (w_state_n == S_LOAD_W);
    w_lda     = 1'b0;
    w_stall   = 1'b1;
    w_mac     = 1'b0;
    w_ub_addr = '0;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_add     = 1'b0;
    w_rd_addr = '0;
    w_wr_addr = '0;
    w_mask    = '0;
    if (w_state_n == S_WAIT_ACT) begin
      w_lda     = 1'b1;
      w_ub_addr = w_ub_k;
    end
    if (w_state_n == S_COMPUTE) begin
      w_mac     = 1'b1;
      w_stall   = 1'b0;
      w_lda     = (w_p_n < w_r);
      w_ub_addr = w_ub_k + UW'(w_off);
      w_add     = (w_k_n != '0) | r_accum;
      w_wr      = (w_p_n >= PW'(MUL_SIZE));
      if (w_wr) begin
        w_wr_addr = w_acc_n + AW'(w_p_n) - AW'(MUL_SIZE);
      end
      w_rd = w_add && (w_p_n >= PW'(MUL_SIZE - 1))
                   && (w_p_n < w_plast);
      if (w_rd) begin
        w_rd_addr = w_acc_n + AW'(w_p_n) - AW'(MUL_SIZE - 1);
      end
      for (int l = 0; l < MUL_SIZE; l++) begin
        w_mask[MUL_SIZE-1-l] =
          (w_p_n >= PW'(MUL_SIZE + l)) &&
          (w_p_n < PW'(MUL_SIZE + l) + w_r);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_beat  <= '0;
      r_k     <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_state_n;
      r_p     <= w_p_n;
      r_beat  <= w_beat_n;
      r_k     <= w_k_n;
      r_n     <= w_n_n;
    end
  end

  // Configuration snapshot taken only when an operation starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rows  <= '0;
      r_kt    <= '0;
      r_nt    <= '0;
      r_ub    <= '0;
      r_acc   <= '0;
      r_accum <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.start_i) begin
      r_rows  <= bus.cfg_rows_i;
      r_kt    <= bus.cfg_k_tiles_i;
      r_nt    <= bus.cfg_n_tiles_i;
      r_ub    <= bus.cfg_ub_base_i;
      r_acc   <= bus.cfg_acc_base_i;
      r_accum <= bus.cfg_accumulate_i;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ldw     <= 1'b0;
      r_lda     <= 1'b0;
      r_stall   <= 1'b1;
      r_mac     <= 1'b0;
      r_ub_addr <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_add     <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_mask    <= '0;
    end else begin
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_ldw     <= w_ldw;
      r_lda     <= w_lda;
      r_stall   <= w_stall;
      r_mac     <= w_mac;
      r_ub_addr <= w_ub_addr;
      r_rd      <= w_rd;
      r_wr      <= w_wr;
      r_add     <= w_add;
      r_rd_addr <= w_rd_addr;
      r_wr_addr <= w_wr_addr;
      r_mask    <= w_mask;
    end
  end

  assign bus.busy_o             = r_busy;
  assign bus.done_o             = r_done;
  assign bus.load_weights_o     = r_ldw;
  assign bus.load_activations_o = r_lda;
  assign bus.stall_compute_o    = r_stall;
  assign bus.mac_compute_o      = r_mac;
  assign bus.ub_addr_rd_o       = r_ub_addr;
  assign bus.acc_rd_o           = r_rd;
  assign bus.acc_wr_o           = r_wr;
  assign bus.acc_add_o          = r_add;
  assign bus.acc_addr_rd_o      = r_rd_addr;
  assign bus.acc_addr_wr_o      = r_wr_addr;
  assign bus.acc_mask_o         = r_mask;
endmodule
